// File: rtl/udp_pixel_packer_if.sv
// Byte-stream input and FIFO write port of udp_pixel_packer.
// The slave modport is the packer; master is whatever drives rx_* and hosts the FIFO.
interface udp_pixel_packer_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_last;
    logic        fifo_full;
    logic        fifo_almost_full;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;

    modport master (
        output rx_valid, rx_data, rx_last, fifo_full, fifo_almost_full,
        input  fifo_wr_en, fifo_wr_data
    );

    modport slave (
        input  rx_valid, rx_data, rx_last, fifo_full, fifo_almost_full,
        output fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/udp_pixel_packer.sv
// Strips and checks a 4-byte line header from the UDP payload and packs pixel bytes into 32-bit FIFO words.
// Statistics counters pkt_cnt/drop_cnt are built only when UDP_PIXEL_PACKER_STATS_EN is defined.
module udp_pixel_packer #(
    parameter logic [7:0] MAGIC = 8'h5A,
    parameter int         CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    udp_pixel_packer_if.slave bus,
    output logic             frame_sync,
    output logic [15:0]      line_num,
    output logic             hdr_err,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [1:0]       state_dbg
);

    // rx_* carries no ready: a byte is consumed on every cycle rx_valid is high, and
    // fifo_wr_en is a one-cycle write strobe with no acknowledge from the FIFO.
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2, DROP = 2'd3} state_t;

    state_t      state, state_n;
    logic [1:0]  hdr_idx, hdr_idx_n;
    logic [1:0]  byte_idx, byte_idx_n;
    logic        sof, sof_n;
    logic [7:0]  line_hi, line_hi_n;
    logic [23:0] asm_q, asm_n;
    logic        wr_en_q, wr_en_n;
    logic [31:0] wr_data_q, wr_data_n;
    logic        frame_sync_n;
    logic [15:0] line_num_n;
    logic        hdr_err_n;
    logic        pkt_inc, drop_inc;
    logic [31:0] word;

    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_wr_data = wr_data_q;
    assign state_dbg        = state;

    always_comb begin
        state_n      = state;
        hdr_idx_n    = hdr_idx;
        byte_idx_n   = byte_idx;
        sof_n        = sof;
        line_hi_n    = line_hi;
        asm_n        = asm_q;
        wr_en_n      = 1'b0;
        wr_data_n    = wr_data_q;
        frame_sync_n = 1'b0;
        line_num_n   = line_num;
        hdr_err_n    = 1'b0;
        pkt_inc      = 1'b0;
        drop_inc     = 1'b0;
        word         = 32'h0;

        // Bytes already collected sit left-aligned; the current byte fills the next lane.
        case (byte_idx)
            2'd0:    word = {bus.rx_data, 24'h0};
            2'd1:    word = {asm_q[23:16], bus.rx_data, 16'h0};
            2'd2:    word = {asm_q[23:8], bus.rx_data, 8'h0};
            default: word = {asm_q, bus.rx_data};
        endcase

        if (bus.rx_valid) begin
            case (state)
                IDLE: begin
                    if (bus.rx_data != MAGIC || bus.rx_last) begin
                        hdr_err_n = 1'b1;
                        state_n   = bus.rx_last ? IDLE : DROP;
                    end else begin
                        state_n   = HDR;
                        hdr_idx_n = 2'd1;
                    end
                end
                HDR: begin
                    if (hdr_idx == 2'd1) sof_n = bus.rx_data[0];
                    if (hdr_idx == 2'd2) line_hi_n = bus.rx_data;
                    if (hdr_idx != 2'd3) begin
                        if (bus.rx_last) begin
                            hdr_err_n = 1'b1;
                            hdr_idx_n = 2'd0;
                            state_n   = IDLE;
                        end else begin
                            hdr_idx_n = hdr_idx + 2'd1;
                        end
                    end else begin
                        hdr_idx_n  = 2'd0;
                        byte_idx_n = 2'd0;
                        if (bus.fifo_almost_full) begin
                            drop_inc = 1'b1;
                            state_n  = bus.rx_last ? IDLE : DROP;
                        end else begin
                            line_num_n   = {line_hi, bus.rx_data};
                            frame_sync_n = sof;
                            pkt_inc      = 1'b1;
                            state_n      = bus.rx_last ? IDLE : DATA;
                        end
                    end
                end
                DATA: begin
                    if (byte_idx == 2'd3 || bus.rx_last) begin
                        byte_idx_n = 2'd0;
                        if (!bus.fifo_full) begin
                            wr_en_n   = 1'b1;
                            wr_data_n = word;
                            if (bus.rx_last) state_n = IDLE;
                        end else begin
                            drop_inc = 1'b1;
                            state_n  = bus.rx_last ? IDLE : DROP;
                        end
                    end else begin
                        byte_idx_n = byte_idx + 2'd1;
                        asm_n      = word[31:8];
                    end
                end
                default: begin
                    if (bus.rx_last) state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            hdr_idx    <= 2'd0;
            byte_idx   <= 2'd0;
            sof        <= 1'b0;
            line_hi    <= 8'h0;
            asm_q      <= 24'h0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= 32'h0;
            frame_sync <= 1'b0;
            line_num   <= 16'h0;
            hdr_err    <= 1'b0;
        end else begin
            state      <= state_n;
            hdr_idx    <= hdr_idx_n;
            byte_idx   <= byte_idx_n;
            sof        <= sof_n;
            line_hi    <= line_hi_n;
            asm_q      <= asm_n;
            wr_en_q    <= wr_en_n;
            wr_data_q  <= wr_data_n;
            frame_sync <= frame_sync_n;
            line_num   <= line_num_n;
            hdr_err    <= hdr_err_n;
        end
    end

`ifdef UDP_PIXEL_PACKER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (pkt_inc)  pkt_cnt  <= pkt_cnt + CNT_W'(1);
            if (drop_inc) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_stats;
    assign unused_stats = pkt_inc | drop_inc;
    assign pkt_cnt      = '0;
    assign drop_cnt     = '0;
`endif

endmodule
